// File: rtl/sync_ram_ctl.sv
// Single-port synchronous RAM (DATA_W x 2^ADDR_W) with req/ready handshake,
// registered read port with valid strobe, and a hardware clear-all sequencer.
module sync_ram_ctl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req,
   input  logic              rw,
   input  logic [ADDR_W-1:0] addr,
   input  logic [DATA_W-1:0] wdata,
   input  logic              clr,
   output logic              ready,
   output logic              rvalid,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic {
      S_CLEAR,
      S_IDLE
   } state_t;

   state_t            state;
   state_t            state_nxt;
   logic [ADDR_W-1:0] cnt;
   logic [ADDR_W-1:0] cnt_nxt;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              accept;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_waddr;
   logic [DATA_W-1:0] mem_wdata;
   logic              rd_en;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_CLEAR;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   // cnt wraps to zero by itself on the last clear edge, so no explicit reload
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         S_CLEAR: begin
            cnt_nxt = cnt + ADDR_W'(1);
            if (cnt == '1) begin
               state_nxt = S_IDLE;
            end
         end
         S_IDLE: begin
            if (clr) begin
               state_nxt = S_CLEAR;
               cnt_nxt   = '0;
            end
         end
         default: begin
            state_nxt = S_CLEAR;
            cnt_nxt   = '0;
         end
      endcase
   end

   // clr outranks req: a request on the same edge as clr is dropped
   always_comb begin
      ready     = (state == S_IDLE);
      accept    = 1'b0;
      mem_we    = 1'b0;
      mem_waddr = '0;
      mem_wdata = '0;
      rd_en     = 1'b0;
      case (state)
         S_CLEAR: begin
            mem_we    = 1'b1;
            mem_waddr = cnt;
            mem_wdata = '0;
         end
         S_IDLE: begin
            accept = req && !clr;
            if (accept && rw) begin
               mem_we    = 1'b1;
               mem_waddr = addr;
               mem_wdata = wdata;
            end
            rd_en = accept && !rw;
         end
         default: begin
            mem_we = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rvalid <= 1'b0;
         rdata  <= '0;
      end else begin
         rvalid <= rd_en;
         if (rd_en) begin
            rdata <= mem[addr];
         end
      end
   end

endmodule

// File: tb/tb_sync_ram_ctl.sv
// Self-checking bench: two sync_ram_ctl instances (8x4 and 16x16) share one
// stimulus stream and are compared each cycle against a behavioural model.
module tb_sync_ram_ctl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req;
   logic        rw;
   logic        clr;
   logic [3:0]  addr;
   logic [15:0] wdata;

   logic        ready_a;
   logic        rvalid_a;
   logic [7:0]  rdata_a;
   logic        ready_b;
   logic        rvalid_b;
   logic [15:0] rdata_b;

   always #5 clk = ~clk;

   sync_ram_ctl #(.DATA_W(8), .ADDR_W(2)) dut_a (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .rw     (rw),
      .addr   (addr[1:0]),
      .wdata  (wdata[7:0]),
      .clr    (clr),
      .ready  (ready_a),
      .rvalid (rvalid_a),
      .rdata  (rdata_a)
   );

   sync_ram_ctl #(.DATA_W(16), .ADDR_W(4)) dut_b (
      .clk    (clk),
      .rst_n  (rst_n),
      .req    (req),
      .rw     (rw),
      .addr   (addr),
      .wdata  (wdata),
      .clr    (clr),
      .ready  (ready_b),
      .rvalid (rvalid_b),
      .rdata  (rdata_b)
   );

   int checks   = 0;
   int failures = 0;

   // model: remaining clear edges, memory image, expected read port
   int          depth [2] = '{4, 16};
   int          left  [2];
   logic [15:0] mm    [2][16];
   logic [15:0] erd   [2];
   logic        erv   [2];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int d = 0; d < 2; d++) begin
         left[d] = depth[d];
         erd[d]  = '0;
         erv[d]  = 1'b0;
         for (int k = 0; k < 16; k++) mm[d][k] = '0;
      end
   endtask

   task automatic model_step();
      int          idx;
      logic [15:0] w;
      for (int d = 0; d < 2; d++) begin
         idx = (d == 0) ? int'(addr[1:0]) : int'(addr);
         w   = (d == 0) ? {8'h00, wdata[7:0]} : wdata;
         if (left[d] > 0) begin
            left[d]--;
            erv[d] = 1'b0;
         end else if (clr) begin
            left[d] = depth[d];
            erv[d]  = 1'b0;
            for (int k = 0; k < 16; k++) mm[d][k] = '0;
         end else if (req && rw) begin
            mm[d][idx] = w;
            erv[d]     = 1'b0;
         end else if (req) begin
            erd[d] = mm[d][idx];
            erv[d] = 1'b1;
         end else begin
            erv[d] = 1'b0;
         end
      end
   endtask

   task automatic compare_all();
      check("a_ready",  ready_a,  left[0] == 0);
      check("a_rvalid", rvalid_a, erv[0]);
      check("a_rdata",  rdata_a,  erd[0]);
      check("b_ready",  ready_b,  left[1] == 0);
      check("b_rvalid", rvalid_b, erv[1]);
      check("b_rdata",  rdata_b,  erd[1]);
   endtask

   task automatic cycle(input logic r, input logic w, input logic c,
                        input logic [3:0] a, input logic [15:0] d);
      req   = r;
      rw    = w;
      clr   = c;
      addr  = a;
      wdata = d;
      @(posedge clk);
      if (rst_n) model_step();
      #1;
      compare_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 4'h0, 16'h0);
   endtask

   task automatic wr(input logic [3:0] a, input logic [15:0] d);
      cycle(1'b1, 1'b1, 1'b0, a, d);
   endtask

   task automatic rd(input logic [3:0] a);
      cycle(1'b1, 1'b0, 1'b0, a, 16'h0);
   endtask

   task automatic apply_reset();
      rst_n = 1'b0;
      model_reset();
      #1;
      compare_all();
      idle(1);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req   = 1'b0;
      rw    = 1'b0;
      clr   = 1'b0;
      addr  = '0;
      wdata = '0;
      model_reset();
      #12;
      compare_all();
      @(posedge clk);
      #3;
      rst_n = 1'b1;

      // clear after reset: A ready after 4 edges, B after 16
      idle(3);
      check("a_ready_edge3", ready_a, 1'b0);
      idle(1);
      check("a_ready_edge4", ready_a, 1'b1);
      idle(12);
      check("b_ready_edge16", ready_b, 1'b1);

      for (int i = 0; i < 4; i++) rd(4'(i));
      idle(1);

      wr(4'd1, 16'h00A5);
      wr(4'd2, 16'h003C);
      wr(4'd3, 16'h00FF);
      rd(4'd1);
      check("a_rd1", rdata_a, 8'hA5);
      rd(4'd2);
      check("a_rd2", rdata_a, 8'h3C);
      rd(4'd3);
      check("a_rd3", rdata_a, 8'hFF);
      idle(1);
      check("a_hold_rdata", rdata_a, 8'hFF);
      check("a_hold_rvalid", rvalid_a, 1'b0);

      wr(4'd0, 16'h005A);
      rd(4'd0);
      check("a_wr_rd_same", rdata_a, 8'h5A);

      // clr with simultaneous write: write dropped, memory zeroed
      cycle(1'b1, 1'b1, 1'b1, 4'd2, 16'h0077);
      check("a_clr_ready", ready_a, 1'b0);
      idle(16);
      rd(4'd2);
      check("a_clr_rd2", rdata_a, 8'h00);
      rd(4'd3);
      check("a_clr_rd3", rdata_a, 8'h00);

      wr(4'd15, 16'hBEEF);
      wr(4'd0,  16'h1234);
      rd(4'd15);
      check("b_rd15", rdata_b, 16'hBEEF);
      rd(4'd0);
      check("b_rd0", rdata_b, 16'h1234);
      for (int i = 1; i < 15; i++) rd(4'(i));

      // reset in the middle of a clear sequence
      cycle(1'b0, 1'b0, 1'b1, 4'd0, 16'h0);
      idle(2);
      apply_reset();
      check("rst_rvalid", rvalid_a, 1'b0);
      idle(16);
      rd(4'd1);

      for (int i = 0; i < 800; i++) begin
         if (i == 400) apply_reset();
         cycle($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
               $urandom_range(0, 40) == 0, 4'($urandom_range(0, 15)),
               16'($urandom));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
